// File: rtl/dau_input_parser.sv
// dau_input_parser: turns the DAU symbol stream into BCDU CLR/LDD instructions
// and reports sign, comma position, digit count and error for each number.
// Symbols that are not part of a number pass straight through.

`ifndef DAU_SYM_WIDTH
`define DAU_SYM_WIDTH 6
`endif
`ifndef DAU_SYM_COMMA
`define DAU_SYM_COMMA 6'h2C
`endif
`ifndef DAU_SYM_MINUS
`define DAU_SYM_MINUS 6'h2D
`endif
`ifndef BCDU_OP_CLR
`define BCDU_OP_CLR 4'h1
`endif
`ifndef BCDU_OP_LDD
`define BCDU_OP_LDD 4'h2
`endif

module dau_input_parser #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned COMMA_WIDTH = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [`DAU_SYM_WIDTH-1:0]         i_symbol,
    input  logic                              i_symbol_valid,
    output logic                              o_symbol_ready,
    input  logic [3:0]                        i_bcdu_addr,
    input  logic                              i_bcdu_ready,
    output logic [15:0]                       o_bcdu_instr,
    output logic                              o_bcdu_instr_valid,
    output logic [`DAU_SYM_WIDTH-1:0]         o_symbol,
    output logic                              o_symbol_valid,
    output logic                              o_num_done,
    output logic                              o_sign,
    output logic [COMMA_WIDTH-1:0]            o_comma,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   o_num_digits,
    output logic                              o_num_error
);

    localparam int unsigned SYM_W = `DAU_SYM_WIDTH;
    localparam int unsigned DIG_W = $clog2(NUM_DIGITS + 1);

    localparam logic [SYM_W-1:0] SYM_COMMA = SYM_W'(`DAU_SYM_COMMA);
    localparam logic [SYM_W-1:0] SYM_MINUS = SYM_W'(`DAU_SYM_MINUS);
    localparam logic [3:0]       OP_CLR    = 4'(`BCDU_OP_CLR);
    localparam logic [3:0]       OP_LDD    = 4'(`BCDU_OP_LDD);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SIGN_PEND = 3'd1,
        REPLAY    = 3'd2,
        CLEAR     = 3'd3,
        ISSUE     = 3'd4,
        COLLECT   = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t state_q;
    state_t state_n;

    // Datapath registers and their next values
    logic                   sign_q,      sign_n;
    logic                   got_comma_q, got_comma_n;
    logic [COMMA_WIDTH-1:0] frac_q,      frac_n;
    logic [DIG_W-1:0]       digits_q,    digits_n;
    logic                   error_q,     error_n;
    logic [3:0]             dig_q,       dig_n;
    logic                   have_dig_q,  have_dig_n;
    logic [SYM_W-1:0]       held_q,      held_n;
    logic [3:0]             addr_q,      addr_n;

    // Decoded view of the symbol being processed this cycle
    logic [SYM_W-1:0] proc_sym;
    logic             proc_valid;
    logic [3:0]       sym_d;
    logic             is_digit;
    logic             is_comma;
    logic             is_minus;
    logic             is_term;
    logic             start_c;
    logic             overflow_c;

    // Registered-output next values
    logic             ready_c;
    logic             instr_valid_c;
    logic [15:0]      instr_c;
    logic             sym_valid_c;
    logic [SYM_W-1:0] sym_c;
    logic             done_c;
    logic             clear_entry_c;

    // Symbol source selection: REPLAY re-processes the held symbol as if freshly accepted
    always_comb begin
        proc_sym   = (state_q == REPLAY) ? held_q : i_symbol;
        proc_valid = (state_q == REPLAY) || (i_symbol_valid && o_symbol_ready);
        sym_d      = proc_sym[3:0];
        is_digit   = (&proc_sym[SYM_W-1:4]) && (sym_d <= 4'd9);
        is_comma   = (proc_sym == SYM_COMMA);
        is_minus   = (proc_sym == SYM_MINUS);
        is_term    = !(is_digit || is_comma || is_minus);
        start_c    = proc_valid && (is_digit || is_comma) &&
                     ((state_q == IDLE) || (state_q == REPLAY) || (state_q == SIGN_PEND));
        overflow_c = (digits_q == DIG_W'(NUM_DIGITS)) ||
                     (got_comma_q && (&frac_q));
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE, REPLAY: begin
                if (state_q == REPLAY) begin
                    state_n = IDLE;
                end
                if (proc_valid) begin
                    if (is_minus) begin
                        state_n = SIGN_PEND;
                    end else if (is_digit || is_comma) begin
                        state_n = CLEAR;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            SIGN_PEND: begin
                if (proc_valid) begin
                    state_n = (is_digit || is_comma) ? CLEAR : REPLAY;
                end
            end
            CLEAR: begin
                if (i_bcdu_ready) begin
                    state_n = have_dig_q ? ISSUE : COLLECT;
                end
            end
            ISSUE: begin
                if (i_bcdu_ready) begin
                    state_n = COLLECT;
                end
            end
            COLLECT: begin
                if (proc_valid) begin
                    if (is_digit) begin
                        state_n = overflow_c ? COLLECT : ISSUE;
                    end else if (is_comma) begin
                        state_n = COLLECT;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath next values: sign, comma flag, counters, latched digit, held symbol
    always_comb begin
        sign_n      = sign_q;
        got_comma_n = got_comma_q;
        frac_n      = frac_q;
        digits_n    = digits_q;
        error_n     = error_q;
        dig_n       = dig_q;
        have_dig_n  = have_dig_q;
        held_n      = held_q;
        addr_n      = addr_q;
        if (start_c) begin
            sign_n      = (state_q == SIGN_PEND);
            got_comma_n = is_comma;
            frac_n      = '0;
            digits_n    = '0;
            error_n     = 1'b0;
            dig_n       = sym_d;
            have_dig_n  = is_digit;
            addr_n      = i_bcdu_addr;
        end else begin
            case (state_q)
                SIGN_PEND: begin
                    if (proc_valid) begin
                        held_n = proc_sym;
                    end
                end
                ISSUE: begin
                    if (i_bcdu_ready) begin
                        digits_n   = digits_q + DIG_W'(1);
                        have_dig_n = 1'b0;
                        if (got_comma_q) begin
                            frac_n = frac_q + COMMA_WIDTH'(1);
                        end
                    end
                end
                COLLECT: begin
                    if (proc_valid) begin
                        if (is_digit) begin
                            if (overflow_c) begin
                                error_n = 1'b1;
                            end else begin
                                dig_n      = sym_d;
                                have_dig_n = 1'b1;
                            end
                        end else if (is_comma) begin
                            if (got_comma_q) begin
                                error_n = 1'b1;
                            end else begin
                                got_comma_n = 1'b1;
                            end
                        end else begin
                            held_n = proc_sym;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sign_q      <= 1'b0;
            got_comma_q <= 1'b0;
            frac_q      <= '0;
            digits_q    <= '0;
            error_q     <= 1'b0;
            dig_q       <= '0;
            have_dig_q  <= 1'b0;
            held_q      <= '0;
            addr_q      <= '0;
        end else begin
            sign_q      <= sign_n;
            got_comma_q <= got_comma_n;
            frac_q      <= frac_n;
            digits_q    <= digits_n;
            error_q     <= error_n;
            dig_q       <= dig_n;
            have_dig_q  <= have_dig_n;
            held_q      <= held_n;
            addr_q      <= addr_n;
        end
    end

    // Output next values, decoded from the upcoming state
    always_comb begin
        ready_c       = (state_n == IDLE) || (state_n == SIGN_PEND) || (state_n == COLLECT);
        instr_valid_c = (state_n == CLEAR) || (state_n == ISSUE);
        instr_c       = 16'h0000;
        if (state_n == CLEAR) begin
            instr_c = {OP_CLR, addr_n, 8'h00};
        end else if (state_n == ISSUE) begin
            instr_c = {OP_LDD, addr_n, 4'h0, dig_n};
        end
        sym_valid_c = 1'b0;
        sym_c       = proc_sym;
        case (state_q)
            IDLE, REPLAY: begin
                sym_valid_c = proc_valid && is_term;
            end
            SIGN_PEND: begin
                if (proc_valid && !(is_digit || is_comma)) begin
                    sym_valid_c = 1'b1;
                    sym_c       = SYM_MINUS;
                end
            end
            COLLECT: begin
                sym_valid_c = (state_n == DONE);
            end
            default: begin
            end
        endcase
        done_c        = (state_n == DONE);
        clear_entry_c = (state_n == CLEAR) && (state_q != CLEAR);
    end

    // Output registers; number report holds from DONE until the next number starts
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_symbol_ready     <= 1'b0;
            o_bcdu_instr       <= 16'h0000;
            o_bcdu_instr_valid <= 1'b0;
            o_symbol           <= '0;
            o_symbol_valid     <= 1'b0;
            o_num_done         <= 1'b0;
            o_sign             <= 1'b0;
            o_comma            <= '0;
            o_num_digits       <= '0;
            o_num_error        <= 1'b0;
        end else begin
            o_symbol_ready     <= ready_c;
            o_bcdu_instr       <= instr_c;
            o_bcdu_instr_valid <= instr_valid_c;
            o_symbol_valid     <= sym_valid_c;
            o_num_done         <= done_c;
            if (sym_valid_c) begin
                o_symbol <= sym_c;
            end
            if (done_c) begin
                o_sign       <= sign_q;
                o_comma      <= frac_q;
                o_num_digits <= digits_q;
                o_num_error  <= error_q;
            end else if (clear_entry_c) begin
                o_sign       <= 1'b0;
                o_comma      <= '0;
                o_num_digits <= '0;
                o_num_error  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dau_input_parser.md
Name: dau_input_parser

Overview:
- Converts the DAU symbol stream (digits, comma, minus, other symbols) into a BCD operand.
- Clears a target BCDU register, then shifts digits into it one at a time, most significant digit first.
- Reports sign, comma position and digit count when the number is complete; all other symbols pass through unchanged.
- Sits between the DAU symbol source and the BCDU instruction port. Its sign/comma encoding matches dau_output_formatter, so a parsed number formats back identically.

Parameters:
- NUM_DIGITS, 4, maximum digits per operand.
- COMMA_WIDTH, 2, width of comma field; value = number of fractional digits.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_symbol  in  `DAU_SYM_WIDTH  input symbol
- i_symbol_valid  in  1  symbol present
- o_symbol_ready  out  1  symbol accepted this cycle when high with valid
- i_bcdu_addr  in  4  target BCDU register
- i_bcdu_ready  in  1  BCDU accepts o_bcdu_instr this cycle
- o_bcdu_instr  out  16  BCDU instruction
- o_bcdu_instr_valid  out  1  instruction valid
- o_symbol  out  `DAU_SYM_WIDTH  passthrough symbol
- o_symbol_valid  out  1  one-cycle pulse
- o_num_done  out  1  one-cycle pulse; number complete
- o_sign  out  1  1 = negative, valid with o_num_done
- o_comma  out  COMMA_WIDTH  fractional digit count, valid with o_num_done
- o_num_digits  out  $clog2(NUM_DIGITS+1)  digits loaded, valid with o_num_done
- o_num_error  out  1  overflow / double comma, valid with o_num_done

Behaviour:
- Symbol classes:
  - digit = {all ones, d}, with d in 0..9.
  - `DAU_SYM_COMMA and `DAU_SYM_MINUS as defined in dau_symbols.vh.
  - any other symbol is a terminator.
- Instruction encodings:
  - CLR = {`BCDU_OP_CLR, i_bcdu_addr, 8'h00}.
  - LDD = {`BCDU_OP_LDD, i_bcdu_addr, 4'h0, d}. LDD shifts the register left one digit and inserts d at the LSD.
  - An instruction is held stable until i_bcdu_ready.
- Reset: state IDLE; all outputs 0; o_bcdu_instr = 16'h0000. Reset mid-number abandons it and issues no further instructions.
- o_symbol_ready is high only in IDLE, SIGN_PEND and COLLECT.
- States:
  - IDLE
    - minus -> SIGN_PEND.
    - digit -> latch d, sign=0 -> CLEAR.
    - comma -> sign=0, got_comma=1 -> CLEAR (integer part 0).
    - terminator -> o_symbol = sym, o_symbol_valid pulse next cycle; stay in IDLE.
  - SIGN_PEND
    - digit -> sign=1, latch d -> CLEAR.
    - comma -> sign=1, got_comma=1 -> CLEAR.
    - terminator or minus -> emit `DAU_SYM_MINUS next cycle, hold sym -> REPLAY.
  - REPLAY (ready low)
    - Re-process the held symbol exactly as IDLE would, one cycle after the minus pulse.
    - A held minus therefore re-enters SIGN_PEND.
  - CLEAR
    - Drive CLR; clear digit/fraction counters.
    - On i_bcdu_ready -> ISSUE if a digit is latched, else COLLECT.
  - ISSUE
    - Drive LDD d.
    - On i_bcdu_ready: digits+1, frac+1 if got_comma -> COLLECT.
  - COLLECT
    - digit:
      - If digits == NUM_DIGITS, or (got_comma and frac == 2^COMMA_WIDTH-1): set error, drop digit.
      - Else latch -> ISSUE.
    - comma:
      - If got_comma: set error.
      - Else got_comma=1.
    - minus or terminator: hold sym -> DONE.
  - DONE
    - o_num_done pulse with o_sign, o_comma = frac, o_num_digits, o_num_error.
    - The same cycle, o_symbol = held terminator with o_symbol_valid.
    - -> IDLE. Error and flags clear on entry to CLEAR.
- Outputs:
  - o_sign, o_comma, o_num_digits and o_num_error hold their values until the next CLEAR.
  - o_bcdu_instr_valid is high only in CLEAR and ISSUE.
- Latency:
  - CLR is valid the cycle after the start symbol is accepted.
  - Per digit: LDD is valid the cycle after acceptance. With BCDU always ready, peak rate is 1 digit per 2 cycles.
- Trailing comma with no fractional digits gives o_comma = 0.
- A lone "," gives a zero value with digits = 0.

Test Plan:
- NUM_DIGITS=4, COMMA_WIDTH=2, bcdu_ready=1. Symbols "-","1","2",",","5","+" -> instructions CLR, LDD 1, LDD 2, LDD 5; o_num_done with sign=1, comma=1, digits=3, error=0; "+" passthrough in the same cycle.
- Symbols "-","+" -> no instructions; o_symbol "-" then "+" on consecutive pulse cycles; no o_num_done.
- Symbols "1","2","3","4","5", terminator -> LDD 1..4 only; done with digits=4, error=1.
- Symbols "7",",",",","2", terminator -> LDD 7, LDD 2; comma=1, error=1.
- Stall: i_bcdu_ready low 5 cycles during an LDD -> instruction stable, o_symbol_ready low, no symbol lost.
- Reset asserted in ISSUE -> next cycle instr_valid=0, all outputs 0, state IDLE; a following "9", terminator parses cleanly (sign=0, digits=1).
